park_gate_sensor: RTL and testbench

//  Gate-side front end producing the car_in / car_out event pulses consumed by the car counter.

---
 rtl/park_gate_sensor_if.sv | 39 +++
 rtl/park_gate_sensor.sv | 200 ++++++++++++++++++++
 tb/tb_park_gate_sensor.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/park_gate_sensor_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : park_gate_sensor_if                                          |
// | Description : Gate-lane sensor inputs and event/barrier outputs            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface park_gate_sensor_if;
  logic sensor_a;
  logic sensor_b;
  logic parking_full;
  logic car_in;
  logic car_out;
  logic barrier_up;
  logic entry_denied;
  logic seq_error;

  modport master (
    output sensor_a,
    output sensor_b,
    output parking_full,
    input  car_in,
    input  car_out,
    input  barrier_up,
    input  entry_denied,
    input  seq_error
  );

  modport slave (
    input  sensor_a,
    input  sensor_b,
    input  parking_full,
    output car_in,
    output car_out,
    output barrier_up,
    output entry_denied,
    output seq_error
  );
endinterface
`default_nettype wire

// File: rtl/park_gate_sensor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : park_gate_sensor                                             |
// | Description : Two-beam gate decoder: direction, barrier and event pulses   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module park_gate_sensor #(
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic              clk,
  input  logic              rst,
  park_gate_sensor_if.slave gate
);

  localparam int c_deb_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int c_tmr_w = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_IN_A   = 4'd1,
    S_IN_AB  = 4'd2,
    S_IN_B   = 4'd3,
    S_OUT_B  = 4'd4,
    S_OUT_BA = 4'd5,
    S_OUT_A  = 4'd6,
    S_DENY   = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_deb;

  assign w_raw = {gate.sensor_b, gate.sensor_a};

  // Per-beam synchronizer and debounce; bit 0 is beam A, bit 1 is beam B.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
    logic               r_sync1;
    logic               r_sync2;
    logic               r_deb;
    logic [c_deb_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
      if (!rst) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
        r_deb   <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_deb) begin
          r_cnt <= '0;
        end else if (r_cnt == c_deb_last) begin
          r_deb <= ~r_deb;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + c_deb_w'(1);
        end
      end
    end

    assign w_deb[gi] = r_deb;
  end

  state_t             r_state;
  state_t             w_next;
  logic [c_tmr_w-1:0] r_timer;
  logic               w_active;
  logic               w_car_in;
  logic               w_car_out;
  logic               w_seq_err;
  logic               r_car_in;
  logic               r_car_out;
  logic               r_seq_err;
  logic               r_barrier;
  logic               r_denied;

  assign w_active = (r_state inside {S_IN_A, S_IN_AB, S_IN_B, S_OUT_B, S_OUT_BA, S_OUT_A});

  always_comb begin
    w_next    = r_state;
    w_car_in  = 1'b0;
    w_car_out = 1'b0;
    // Case items are {da, db}.
    case (r_state)
      S_IDLE: begin
        case (w_deb[0+:1] == 1'b1 ? {1'b1, w_deb[1]} : {1'b0, w_deb[1]})
          2'b10:   w_next = gate.parking_full ? S_DENY : S_IN_A;
          2'b01:   w_next = S_OUT_B;
          2'b11:   w_next = S_ERR;
          default: w_next = S_IDLE;
        endcase
      end
      S_IN_A: begin
        case ({w_deb[0], w_deb[1]})
          2'b11:   w_next = S_IN_AB;
          2'b00:   w_next = S_IDLE;
          2'b01:   w_next = S_ERR;
          default: w_next = S_IN_A;
        endcase
      end
      S_IN_AB: begin
        case ({w_deb[0], w_deb[1]})
          2'b01:   w_next = S_IN_B;
          2'b10:   w_next = S_IN_A;
          2'b00:   w_next = S_IDLE;
          default: w_next = S_IN_AB;
        endcase
      end
      S_IN_B: begin
        case ({w_deb[0], w_deb[1]})
          2'b00: begin
            w_next   = S_IDLE;
            w_car_in = 1'b1;
          end
          2'b11:   w_next = S_IN_AB;
          2'b10:   w_next = S_ERR;
          default: w_next = S_IN_B;
        endcase
      end
      S_OUT_B: begin
        case ({w_deb[0], w_deb[1]})
          2'b11:   w_next = S_OUT_BA;
          2'b00:   w_next = S_IDLE;
          2'b10:   w_next = S_ERR;
          default: w_next = S_OUT_B;
        endcase
      end
      S_OUT_BA: begin
        case ({w_deb[0], w_deb[1]})
          2'b10:   w_next = S_OUT_A;
          2'b01:   w_next = S_OUT_B;
          2'b00:   w_next = S_IDLE;
          default: w_next = S_OUT_BA;
        endcase
      end
      S_OUT_A: begin
        case ({w_deb[0], w_deb[1]})
          2'b00: begin
            w_next    = S_IDLE;
            w_car_out = 1'b1;
          end
          2'b11:   w_next = S_OUT_BA;
          2'b01:   w_next = S_ERR;
          default: w_next = S_OUT_A;
        endcase
      end
      S_DENY, S_ERR: begin
        if (w_deb == 2'b00) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase

    // A stalled vehicle overrides whatever the beams currently show.
    if (w_active && (r_timer == c_tmr_last)) begin
      w_next    = S_ERR;
      w_car_in  = 1'b0;
      w_car_out = 1'b0;
    end

    w_seq_err = (w_next == S_ERR) && (r_state != S_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_car_in  <= 1'b0;
      r_car_out <= 1'b0;
      r_seq_err <= 1'b0;
      r_barrier <= 1'b0;
      r_denied  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((w_next != r_state) || !w_active) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + c_tmr_w'(1);
      end
      r_car_in  <= w_car_in;
      r_car_out <= w_car_out;
      r_seq_err <= w_seq_err;
      r_barrier <= (w_next inside {S_IN_A, S_IN_AB, S_IN_B, S_OUT_B, S_OUT_BA, S_OUT_A});
      r_denied  <= (w_next == S_DENY);
    end
  end

  assign gate.car_in       = r_car_in;
  assign gate.car_out      = r_car_out;
  assign gate.seq_error    = r_seq_err;
  assign gate.barrier_up   = r_barrier;
  assign gate.entry_denied = r_denied;

endmodule
`default_nettype wire

// File: tb/tb_park_gate_sensor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_park_gate_sensor                                          |
// | Description : Directed and random checks of park_gate_sensor vs a model    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_park_gate_sensor;
  localparam int DEB = 4;
  localparam int TMO = 200;
  localparam int DIR_IDLE = 0;
  localparam int DIR_IN   = 1;
  localparam int DIR_OUT  = 2;
  localparam int DIR_DENY = 3;
  localparam int DIR_ERR  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  park_gate_sensor_if gate_if ();

  park_gate_sensor #(.DEB_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst  (rst),
    .gate (gate_if)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: raw-sample history per beam plus a direction/progress view
  // of the lane (progress 1 = leading beam only, 2 = both, 3 = trailing only).
  bit h_a [DEB+2];
  bit h_b [DEB+2];
  bit m_da, m_db;
  int m_dir, m_p, m_age;
  bit e_in, e_out, e_err, e_bar, e_den;
  int seen_in, seen_out, seen_err, seen_bar, seen_den;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_cnt(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit a, input bit b, input bit f);
    int q, nd, np;
    bit lead, trail, flip;
    if (!r) begin
      for (int k = 0; k < DEB + 2; k++) begin
        h_a[k] = 1'b0;
        h_b[k] = 1'b0;
      end
      m_da = 0; m_db = 0; m_dir = DIR_IDLE; m_p = 0; m_age = 0;
      e_in = 0; e_out = 0; e_err = 0; e_bar = 0; e_den = 0;
      return;
    end
    nd = m_dir; np = m_p; e_in = 0; e_out = 0;
    if (m_dir == DIR_IDLE) begin
      if (m_da && !m_db) begin
        if (f) nd = DIR_DENY;
        else begin nd = DIR_IN; np = 1; end
      end else if (!m_da && m_db) begin
        nd = DIR_OUT; np = 1;
      end else if (m_da && m_db) begin
        nd = DIR_ERR;
      end
    end else if (m_dir == DIR_DENY || m_dir == DIR_ERR) begin
      if (!m_da && !m_db) nd = DIR_IDLE;
    end else begin
      lead  = (m_dir == DIR_IN) ? m_da : m_db;
      trail = (m_dir == DIR_IN) ? m_db : m_da;
      q = (!lead && !trail) ? 0 : ((lead && !trail) ? 1 : ((lead && trail) ? 2 : 3));
      if (q == 0) begin
        nd = DIR_IDLE;
        if (m_p == 3) begin
          if (m_dir == DIR_IN) e_in = 1;
          else e_out = 1;
        end
      end else if (q == m_p + 1 || q == m_p - 1) begin
        np = q;
      end else if (q != m_p) begin
        nd = DIR_ERR;
      end
    end
    if ((m_dir == DIR_IN || m_dir == DIR_OUT) && m_age == TMO - 1) begin
      nd = DIR_ERR; e_in = 0; e_out = 0;
    end
    if (nd != DIR_IN && nd != DIR_OUT) np = 0;
    e_err = (nd == DIR_ERR) && (m_dir != DIR_ERR);
    if (nd != m_dir || np != m_p) m_age = 0;
    else if (nd == DIR_IN || nd == DIR_OUT) m_age++;
    else m_age = 0;
    m_dir = nd; m_p = np;
    e_bar = (nd == DIR_IN || nd == DIR_OUT);
    e_den = (nd == DIR_DENY);
    // A beam level is accepted after DEB opposite samples, seen two edges late.
    for (int k = DEB + 1; k > 0; k--) begin
      h_a[k] = h_a[k-1];
      h_b[k] = h_b[k-1];
    end
    h_a[0] = a; h_b[0] = b;
    flip = 1;
    for (int k = 2; k <= DEB + 1; k++) if (h_a[k] == m_da) flip = 0;
    if (flip) m_da = !m_da;
    flip = 1;
    for (int k = 2; k <= DEB + 1; k++) if (h_b[k] == m_db) flip = 0;
    if (flip) m_db = !m_db;
  endtask

  task automatic tick();
    bit r, a, b, f;
    r = rst; a = gate_if.sensor_a; b = gate_if.sensor_b; f = gate_if.parking_full;
    @(posedge clk);
    model_edge(r, a, b, f);
    #1;
    chk("car_in", gate_if.car_in, e_in);
    chk("car_out", gate_if.car_out, e_out);
    chk("seq_error", gate_if.seq_error, e_err);
    chk("barrier_up", gate_if.barrier_up, e_bar);
    chk("entry_denied", gate_if.entry_denied, e_den);
    seen_in  += int'(gate_if.car_in);
    seen_out += int'(gate_if.car_out);
    seen_err += int'(gate_if.seq_error);
    seen_bar += int'(gate_if.barrier_up);
    seen_den += int'(gate_if.entry_denied);
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    gate_if.sensor_a = a;
    gate_if.sensor_b = b;
    repeat (n) tick();
  endtask

  task automatic clr_seen();
    seen_in = 0; seen_out = 0; seen_err = 0; seen_bar = 0; seen_den = 0;
  endtask

  initial begin
    rst = 1'b0;
    gate_if.sensor_a = 1'b0;
    gate_if.sensor_b = 1'b0;
    gate_if.parking_full = 1'b0;
    clr_seen();
    repeat (3) tick();
    rst = 1'b1;
    hold(0, 0, 4);

    // Entry
    clr_seen();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 12);
    chk_cnt("entry_car_in", seen_in, 1);
    chk_cnt("entry_car_out", seen_out, 0);

    // Exit
    clr_seen();
    hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
    chk_cnt("exit_car_out", seen_out, 1);
    chk_cnt("exit_car_in", seen_in, 0);
    chk_cnt("exit_barrier_seen", int'(seen_bar > 0), 1);

    // Refused entry while full
    clr_seen();
    gate_if.parking_full = 1'b1;
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 12);
    gate_if.parking_full = 1'b0;
    chk_cnt("deny_seen", int'(seen_den > 0), 1);
    chk_cnt("deny_barrier", seen_bar, 0);
    chk_cnt("deny_car_in", seen_in, 0);

    // Glitch then back-out
    clr_seen();
    hold(1, 0, 3); hold(0, 0, 12);
    chk_cnt("glitch_barrier", seen_bar, 0);
    chk_cnt("glitch_err", seen_err, 0);
    hold(1, 0, 10); hold(0, 0, 12);
    chk_cnt("backout_barrier_seen", int'(seen_bar > 0), 1);
    chk_cnt("backout_pulses", seen_in + seen_out, 0);

    // Timeout
    clr_seen();
    hold(1, 0, 250); hold(0, 0, 12);
    chk_cnt("timeout_err", seen_err, 1);

    // Reset mid-sequence, then a fresh entry
    clr_seen();
    hold(1, 0, 10); hold(1, 1, 10);
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    hold(0, 1, 10); hold(0, 0, 12);
    chk_cnt("reset_car_in", seen_in, 0);
    clr_seen();
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 12);
    chk_cnt("fresh_car_in", seen_in, 1);

    // Random lane traffic, biased toward ordered walks through the beams
    for (int i = 0; i < 400; i++) begin
      int len;
      int pat;
      int step_sel;
      step_sel = i % 4;
      if ($urandom_range(0, 2) == 0) pat = $urandom_range(0, 3);
      else if ((i / 4) % 2 == 0) pat = (step_sel == 0) ? 1 : (step_sel == 1) ? 3 : (step_sel == 2) ? 2 : 0;
      else pat = (step_sel == 0) ? 2 : (step_sel == 1) ? 3 : (step_sel == 2) ? 1 : 0;
      len = ($urandom_range(0, 39) == 0) ? $urandom_range(205, 240) : $urandom_range(1, 14);
      gate_if.parking_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      hold(pat[0], pat[1], len);
    end
    hold(0, 0, 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
